redmule_mesh_ctrl: RTL

- Per-tile launch and completion controller for the RedMulE mesh.
- Replaces broadcast tile_enable/fetch_enable/mhartid wiring with:
  - per-tile enables,
  - staggered fetch start,
  - mesh-coordinate hart IDs,
  - filtered end-of-computation detection on core_sleep.
- Generalised to an N_TILES_X x N_TILES_Y mesh. Adds masking, timeout and run-cycle accounting.

---
 rtl/redmule_mesh_pkg.sv | 23 ++
 rtl/redmule_mesh_sleep_filter.sv | 48 ++++
 rtl/redmule_mesh_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_mesh_pkg.sv
// Shared types and helpers for the RedMulE mesh launch/completion controller.
package redmule_mesh_pkg;

    localparam int unsigned MESH_N_X = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENABLE = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } mesh_ctrl_state_e;

    typedef logic [31:0] hartid_t;

    // Row-major tile index: i = y * n_x + x.
    function automatic int unsigned tile_idx(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned n_x = MESH_N_X);
        return y * n_x + x;
    endfunction

endpackage

// File: rtl/redmule_mesh_sleep_filter.sv
// Per-tile core_sleep filter: counts consecutive sleep cycles once the tile is
// fetching and raises a sticky done flag after SLEEP_FILTER of them.
module redmule_mesh_sleep_filter #(
    parameter int unsigned SLEEP_FILTER = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic flush_i,
    input  logic en_i,
    input  logic sleep_i,
    output logic done_o
);

    localparam int unsigned FW = $clog2(SLEEP_FILTER + 1);

    logic [FW-1:0] r_cnt;
    logic          r_done;
    logic          w_hit;

    assign w_hit  = en_i && sleep_i && (r_cnt == FW'(SLEEP_FILTER - 1));
    assign done_o = r_done;

    // Run-length counter with saturation; a start clears the sticky flag, an abort only the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt  <= {FW{1'b0}};
            r_done <= 1'b0;
        end else begin
            if (clr_i || flush_i) begin
                r_cnt <= {FW{1'b0}};
            end else if (en_i && sleep_i) begin
                if (r_cnt != FW'(SLEEP_FILTER)) begin
                    r_cnt <= r_cnt + FW'(1);
                end
            end else begin
                r_cnt <= {FW{1'b0}};
            end

            if (clr_i) begin
                r_done <= 1'b0;
            end else if (w_hit) begin
                r_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/redmule_mesh_ctrl.sv
// Per-tile launch and completion controller for an N_TILES_X x N_TILES_Y RedMulE mesh.
// Define REDMULE_MESH_CTRL_PERF_EN to capture per-tile completion cycle counts.
module redmule_mesh_ctrl
    import redmule_mesh_pkg::*;
#(
    parameter int unsigned N_TILES_X      = 2,
    parameter int unsigned N_TILES_Y      = 2,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned SLEEP_FILTER   = 8,
    parameter hartid_t     HARTID_BASE    = 32'd0,
    parameter int unsigned CNT_W          = 32,
    localparam int unsigned N_TILES       = N_TILES_X * N_TILES_Y
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic                              abort_i,
    input  logic [N_TILES-1:0]                tile_mask_i,
    input  logic [CNT_W-1:0]                  timeout_i,
    input  logic [N_TILES-1:0]                core_sleep_i,
    output logic [N_TILES-1:0]                tile_enable_o,
    output logic [N_TILES-1:0]                fetch_enable_o,
    output hartid_t [N_TILES-1:0]             mhartid_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              timeout_o,
    output logic [N_TILES-1:0]                done_mask_o,
    output logic [CNT_W-1:0]                  cycles_o,
    output logic [N_TILES-1:0][CNT_W-1:0]     tile_cycles_o
);

    localparam int unsigned STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

    mesh_ctrl_state_e   r_state;
    mesh_ctrl_state_e   w_next;
    logic [N_TILES-1:0] r_mask;
    logic [N_TILES-1:0] r_pending;
    logic [N_TILES-1:0] r_tile_en;
    logic [N_TILES-1:0] r_fetch_en;
    logic [CNT_W-1:0]   r_timeout;
    logic [CNT_W-1:0]   r_cycles;
    logic [STG_W-1:0]   r_stag;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout_flag;

    logic [N_TILES-1:0] w_done_mask;
    logic [N_TILES-1:0] w_low;
    logic               w_busy;
    logic               w_next_busy;
    logic               w_next_fetch;
    logic               w_complete;
    logic               w_all_launched;
    logic               w_stag_hit;
    logic               w_tmo;
    logic               w_accept;
    logic               w_launch;
    logic               w_done_entry;
    logic               w_tmo_hit;

    // Lowest still-pending tile is the next one to launch; unmasked tiles never enter pending.
    assign w_low          = r_pending & (~r_pending + N_TILES'(1));
    assign w_busy         = (r_state == ST_ENABLE) || (r_state == ST_LAUNCH) || (r_state == ST_RUN);
    assign w_next_busy    = (w_next == ST_ENABLE) || (w_next == ST_LAUNCH) || (w_next == ST_RUN);
    assign w_next_fetch   = (w_next == ST_LAUNCH) || (w_next == ST_RUN);
    assign w_complete     = (w_done_mask == r_mask);
    assign w_all_launched = (r_pending == {N_TILES{1'b0}});
    assign w_stag_hit     = (r_stag == STG_W'(STAGGER_CYCLES - 1));
    assign w_tmo          = (r_timeout != {CNT_W{1'b0}}) && (r_cycles == r_timeout - CNT_W'(1));

    // Next-state and event decode; completion takes precedence over timeout.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_launch     = 1'b0;
        w_done_entry = 1'b0;
        w_tmo_hit    = 1'b0;
        if (abort_i) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        w_accept = 1'b1;
                        if (tile_mask_i == {N_TILES{1'b0}}) begin
                            w_next       = ST_DONE;
                            w_done_entry = 1'b1;
                        end else begin
                            w_next = ST_ENABLE;
                        end
                    end else begin
                        w_next = r_state;
                    end
                end
                ST_ENABLE: begin
                    if (w_tmo) begin
                        w_next       = ST_DONE;
                        w_done_entry = 1'b1;
                        w_tmo_hit    = 1'b1;
                    end else begin
                        w_next   = ST_LAUNCH;
                        w_launch = 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    if (w_all_launched && w_complete) begin
                        w_next       = ST_DONE;
                        w_done_entry = 1'b1;
                    end else if (w_tmo) begin
                        w_next       = ST_DONE;
                        w_done_entry = 1'b1;
                        w_tmo_hit    = 1'b1;
                    end else if (w_all_launched) begin
                        w_next = ST_RUN;
                    end else if (w_stag_hit) begin
                        w_launch = 1'b1;
                    end else begin
                        w_next = r_state;
                    end
                end
                ST_RUN: begin
                    if (w_complete) begin
                        w_next       = ST_DONE;
                        w_done_entry = 1'b1;
                    end else if (w_tmo) begin
                        w_next       = ST_DONE;
                        w_done_entry = 1'b1;
                        w_tmo_hit    = 1'b1;
                    end else begin
                        w_next = r_state;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Launch bookkeeping, enables, run counter and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mask         <= {N_TILES{1'b0}};
            r_pending      <= {N_TILES{1'b0}};
            r_timeout      <= {CNT_W{1'b0}};
            r_tile_en      <= {N_TILES{1'b0}};
            r_fetch_en     <= {N_TILES{1'b0}};
            r_stag         <= {STG_W{1'b0}};
            r_cycles       <= {CNT_W{1'b0}};
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mask    <= tile_mask_i;
                r_timeout <= timeout_i;
                r_pending <= tile_mask_i;
            end else if (w_launch) begin
                r_pending <= r_pending & ~w_low;
            end

            r_tile_en  <= w_next_busy ? (w_accept ? tile_mask_i : r_mask) : {N_TILES{1'b0}};
            r_fetch_en <= w_next_fetch ? (r_fetch_en | (w_launch ? w_low : {N_TILES{1'b0}}))
                                       : {N_TILES{1'b0}};
            r_stag     <= (w_launch || (r_state != ST_LAUNCH)) ? {STG_W{1'b0}} : r_stag + STG_W'(1);

            // An abort freezes the run counter along with the other status outputs.
            if (w_accept) begin
                r_cycles <= {CNT_W{1'b0}};
            end else if (w_busy && !abort_i && (r_cycles != {CNT_W{1'b1}})) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end

            if (w_accept) begin
                r_timeout_flag <= 1'b0;
            end else if (w_tmo_hit) begin
                r_timeout_flag <= 1'b1;
            end

            r_busy <= w_next_busy;
            r_done <= w_done_entry;
        end
    end

    for (genvar gi = 0; gi < N_TILES; gi++) begin : g_filter
        redmule_mesh_sleep_filter #(
            .SLEEP_FILTER (SLEEP_FILTER)
        ) u_filter (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clr_i   (w_accept),
            .flush_i (abort_i),
            .en_i    (r_fetch_en[gi]),
            .sleep_i (core_sleep_i[gi]),
            .done_o  (w_done_mask[gi])
        );
    end

    for (genvar gy = 0; gy < N_TILES_Y; gy++) begin : g_hart_y
        for (genvar gx = 0; gx < N_TILES_X; gx++) begin : g_hart_x
            assign mhartid_o[tile_idx(gx, gy, N_TILES_X)] =
                HARTID_BASE + hartid_t'(tile_idx(gx, gy, N_TILES_X));
        end
    end

`ifdef REDMULE_MESH_CTRL_PERF_EN
    logic [N_TILES-1:0][CNT_W-1:0] r_tile_cycles;
    logic [N_TILES-1:0]            r_seen;

    // Timestamp each tile on the first cycle its done flag is visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tile_cycles <= {(N_TILES*CNT_W){1'b0}};
            r_seen        <= {N_TILES{1'b0}};
        end else begin
            r_seen <= w_done_mask;
            for (int i = 0; i < N_TILES; i++) begin
                if (w_accept) begin
                    r_tile_cycles[i] <= {CNT_W{1'b0}};
                end else if (w_done_mask[i] && !r_seen[i]) begin
                    r_tile_cycles[i] <= r_cycles;
                end
            end
        end
    end

    assign tile_cycles_o = r_tile_cycles;
`else
    assign tile_cycles_o = {(N_TILES*CNT_W){1'b0}};
`endif

    assign tile_enable_o  = r_tile_en;
    assign fetch_enable_o = r_fetch_en;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign timeout_o      = r_timeout_flag;
    assign done_mask_o    = w_done_mask;
    assign cycles_o       = r_cycles;

endmodule
